// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard bundle: ID/EX/MEM hazard observations from the datapath
// and the per-register stall/bubble controls plus PC hold back to it.
interface pipe_hazard_ctrl_if;
  logic [4:0] i_ID_rs;
  logic [4:0] i_ID_rt;
  logic       i_ID_uses_rs;
  logic       i_ID_uses_rt;
  logic       i_ID_jump;
  logic       i_EX_Mem2Reg;
  logic       i_EX_RegWrite;
  logic [4:0] i_EX_RegAddrW;
  logic       i_EX_branch_taken;
  logic       i_MEM_req;
  logic       i_MEM_ready;

  logic       o_pc_stall;
  logic       o_IFID_stall;
  logic       o_IFID_bubble;
  logic       o_IDEX_stall;
  logic       o_IDEX_bubble;
  logic       o_EXMEM_stall;
  logic       o_EXMEM_bubble;
  logic       o_MEMWB_stall;
  logic       o_MEMWB_bubble;

  // Datapath side: reports hazards, obeys stall/bubble controls
  modport master (
    output i_ID_rs, i_ID_rt, i_ID_uses_rs, i_ID_uses_rt, i_ID_jump,
    output i_EX_Mem2Reg, i_EX_RegWrite, i_EX_RegAddrW, i_EX_branch_taken,
    output i_MEM_req, i_MEM_ready,
    input  o_pc_stall, o_IFID_stall, o_IFID_bubble, o_IDEX_stall, o_IDEX_bubble,
    input  o_EXMEM_stall, o_EXMEM_bubble, o_MEMWB_stall, o_MEMWB_bubble
  );

  // Hazard controller side
  modport slave (
    input  i_ID_rs, i_ID_rt, i_ID_uses_rs, i_ID_uses_rt, i_ID_jump,
    input  i_EX_Mem2Reg, i_EX_RegWrite, i_EX_RegAddrW, i_EX_branch_taken,
    input  i_MEM_req, i_MEM_ready,
    output o_pc_stall, o_IFID_stall, o_IFID_bubble, o_IDEX_stall, o_IDEX_bubble,
    output o_EXMEM_stall, o_EXMEM_bubble, o_MEMWB_stall, o_MEMWB_bubble
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch/jump flushes, data-memory wait freezes with timeout halt,
// and a saturating count of PC-hold cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz,
  output logic             o_halted,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_freeze;
  logic do_freeze;
  logic do_flow;
  logic do_halt;

  // Controls in order: pc, IFID s/b, IDEX s/b, EXMEM s/b, MEMWB s/b
  logic [8:0] ctl;

  // Hazard detection terms from the current pipeline contents
  always_comb begin
    load_use = hz.i_EX_Mem2Reg & hz.i_EX_RegWrite & (hz.i_EX_RegAddrW != 5'd0) &
               ((hz.i_ID_uses_rs & (hz.i_ID_rs == hz.i_EX_RegAddrW)) |
                (hz.i_ID_uses_rt & (hz.i_ID_rt == hz.i_EX_RegAddrW)));
    mem_freeze = hz.i_MEM_req & ~hz.i_MEM_ready;
  end

  // Next-state, counters and combinational stall/bubble decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    do_freeze   = 1'b0;
    do_flow     = 1'b0;
    do_halt     = 1'b0;
    ctl         = '0;

    case (state_q)
      RUN: begin
        if (mem_freeze) begin
          do_freeze  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          do_flow = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped request counts as completion so the core cannot deadlock
        if (!mem_freeze) begin
          do_flow    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          do_freeze  = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
          if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end
        end
      end
      HALT: do_halt = 1'b1;
      default: state_d = RUN;
    endcase

    if (do_halt) begin
      ctl = 9'b110101010;
    end else if (do_freeze) begin
      ctl = 9'b110101001;
    end else if (do_flow) begin
      if (hz.i_EX_branch_taken) begin
        ctl = 9'b001010000;
      end else if (load_use) begin
        ctl = 9'b110010000;
      end else if (hz.i_ID_jump) begin
        ctl = 9'b001000000;
      end
    end

    if (rst) begin
      ctl = 9'b001010101;
    end

    if (ctl[8] && (state_q != HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.o_pc_stall     = ctl[8];
  assign hz.o_IFID_stall   = ctl[7];
  assign hz.o_IFID_bubble  = ctl[6];
  assign hz.o_IDEX_stall   = ctl[5];
  assign hz.o_IDEX_bubble  = ctl[4];
  assign hz.o_EXMEM_stall  = ctl[3];
  assign hz.o_EXMEM_bubble = ctl[2];
  assign hz.o_MEMWB_stall  = ctl[1];
  assign hz.o_MEMWB_bubble = ctl[0];

  assign o_halted    = (state_q == HALT);
  assign o_mem_err   = mem_err_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO      = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [8:0] P_RST    = 9'b001010101;
  localparam logic [8:0] P_HALT   = 9'b110101010;
  localparam logic [8:0] P_FREEZE = 9'b110101001;
  localparam logic [8:0] P_BRANCH = 9'b001010000;
  localparam logic [8:0] P_LU     = 9'b110010000;
  localparam logic [8:0] P_JUMP   = 9'b001000000;

  logic             clk;
  logic             rst;
  logic             o_halted;
  logic             o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [8:0]       outs;

  int checks;
  int failures;

  // Behavioural model: freeze cycles so far, halted, error, stall count
  int m_wait;
  bit m_halted;
  bit m_err;
  int m_cnt;

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .hz          (hif.slave),
    .o_halted    (o_halted),
    .o_mem_err   (o_mem_err),
    .o_stall_cnt (o_stall_cnt)
  );

  assign outs = {hif.o_pc_stall, hif.o_IFID_stall, hif.o_IFID_bubble,
                 hif.o_IDEX_stall, hif.o_IDEX_bubble, hif.o_EXMEM_stall,
                 hif.o_EXMEM_bubble, hif.o_MEMWB_stall, hif.o_MEMWB_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] exp_outs();
    bit hit;
    if (rst) return P_RST;
    if (m_halted) return P_HALT;
    if (hif.i_MEM_req && !hif.i_MEM_ready) return P_FREEZE;
    if (hif.i_EX_branch_taken) return P_BRANCH;
    hit = (hif.i_ID_uses_rs && hif.i_ID_rs == hif.i_EX_RegAddrW) ||
          (hif.i_ID_uses_rt && hif.i_ID_rt == hif.i_EX_RegAddrW);
    if (hif.i_EX_Mem2Reg && hif.i_EX_RegWrite && hif.i_EX_RegAddrW != 5'd0 && hit)
      return P_LU;
    if (hif.i_ID_jump) return P_JUMP;
    return 9'b0;
  endfunction

  task automatic model_advance();
    logic [8:0] o;
    o = exp_outs();
    if (rst) begin
      m_wait = 0; m_halted = 0; m_err = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (o[8] && m_cnt < CNT_MAX) m_cnt++;
      if (hif.i_MEM_req && !hif.i_MEM_ready) begin
        m_wait++;
        if (m_wait >= TO) begin
          m_halted = 1; m_err = 1;
        end
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    hif.i_ID_rs = 5'd0; hif.i_ID_rt = 5'd0;
    hif.i_ID_uses_rs = 1'b0; hif.i_ID_uses_rt = 1'b0; hif.i_ID_jump = 1'b0;
    hif.i_EX_Mem2Reg = 1'b0; hif.i_EX_RegWrite = 1'b0; hif.i_EX_RegAddrW = 5'd0;
    hif.i_EX_branch_taken = 1'b0; hif.i_MEM_req = 1'b0; hif.i_MEM_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] dst);
    hif.i_EX_Mem2Reg = 1'b1; hif.i_EX_RegWrite = 1'b1; hif.i_EX_RegAddrW = dst;
    hif.i_ID_rs = dst; hif.i_ID_uses_rs = 1'b1;
  endtask

  task automatic set_random();
    hif.i_ID_rs = 5'($urandom_range(0, 3));
    hif.i_ID_rt = 5'($urandom_range(0, 3));
    hif.i_ID_uses_rs = 1'($urandom);
    hif.i_ID_uses_rt = 1'($urandom);
    hif.i_ID_jump = ($urandom_range(0, 3) == 0);
    hif.i_EX_Mem2Reg = 1'($urandom);
    hif.i_EX_RegWrite = ($urandom_range(0, 3) != 0);
    hif.i_EX_RegAddrW = 5'($urandom_range(0, 3));
    hif.i_EX_branch_taken = ($urandom_range(0, 4) == 0);
    hif.i_MEM_req = 1'($urandom);
    hif.i_MEM_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_random();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== P_RST) begin
      failures++;
      $display("FAIL reset_outs: got %b want %b", outs, P_RST);
    end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if (outs !== 9'b0 || o_halted !== 1'b0 || o_mem_err !== 1'b0 || o_stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: outs=%b halted=%b err=%b cnt=%0d want 0/0/0/0",
               outs, o_halted, o_mem_err, o_stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    checks++;
    if (outs !== P_LU) begin
      failures++;
      $display("FAIL load_use_outs: got %b want %b", outs, P_LU);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (outs !== 9'b0 || o_stall_cnt !== CNT_W'(1)) begin
      failures++;
      $display("FAIL load_use_after: outs=%b cnt=%0d want 0 / 1", outs, o_stall_cnt);
    end
    set_load_use(5'd0);
    #1;
    checks++;
    if (outs !== 9'b0) begin
      failures++;
      $display("FAIL load_use_r0: got %b want 0", outs);
    end
    set_idle();
    hif.i_EX_Mem2Reg = 1'b1; hif.i_EX_RegWrite = 1'b1; hif.i_EX_RegAddrW = 5'd7;
    hif.i_ID_rt = 5'd7; hif.i_ID_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs !== P_LU) begin
      failures++;
      $display("FAIL load_use_rt: got %b want %b", outs, P_LU);
    end
    hif.i_ID_uses_rt = 1'b0;
    #1;
    checks++;
    if (outs !== 9'b0) begin
      failures++;
      $display("FAIL load_use_unused_rt: got %b want 0", outs);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_load_use(5'd9);
    hif.i_ID_jump = 1'b1;
    hif.i_EX_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs !== P_BRANCH) begin
      failures++;
      $display("FAIL branch_priority: got %b want %b", outs, P_BRANCH);
    end
    tick();
    set_idle();
    hif.i_ID_jump = 1'b1;
    #1;
    checks++;
    if (outs !== P_JUMP || o_stall_cnt !== '0) begin
      failures++;
      $display("FAIL jump_flush: outs=%b cnt=%0d want %b / 0", outs, o_stall_cnt, P_JUMP);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      hif.i_MEM_req = 1'b1;
      set_load_use(5'd3);
      #1;
      checks++;
      if (outs !== P_FREEZE) begin
        failures++;
        $display("FAIL mem_freeze_%0d: got %b want %b", i, outs, P_FREEZE);
      end
      tick();
    end
    hif.i_MEM_ready = 1'b1;
    set_idle();
    hif.i_MEM_req = 1'b1; hif.i_MEM_ready = 1'b1; hif.i_ID_jump = 1'b1;
    #1;
    checks++;
    if (outs !== P_JUMP) begin
      failures++;
      $display("FAIL mem_release: got %b want %b", outs, P_JUMP);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (outs !== 9'b0 || o_halted !== 1'b0 || o_stall_cnt !== CNT_W'(3)) begin
      failures++;
      $display("FAIL mem_wait_done: outs=%b halted=%b cnt=%0d want 0/0/3",
               outs, o_halted, o_stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_idle();
    hif.i_MEM_req = 1'b1;
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      checks++;
      if (outs !== P_FREEZE || o_halted !== 1'b0) begin
        failures++;
        $display("FAIL timeout_freeze_%0d: outs=%b halted=%b want %b / 0",
                 i, outs, o_halted, P_FREEZE);
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_random();
      #1;
      checks++;
      if (outs !== P_HALT || o_halted !== 1'b1 || o_mem_err !== 1'b1 ||
          o_stall_cnt !== CNT_W'(TO)) begin
        failures++;
        $display("FAIL halt_hold_%0d: outs=%b halted=%b err=%b cnt=%0d want %b/1/1/%0d",
                 i, outs, o_halted, o_mem_err, o_stall_cnt, P_HALT, TO);
      end
      tick();
    end
    do_reset();
    #1;
    checks++;
    if (o_halted !== 1'b0 || o_mem_err !== 1'b0 || outs !== 9'b0) begin
      failures++;
      $display("FAIL halt_exit: halted=%b err=%b outs=%b want 0/0/0", o_halted, o_mem_err, outs);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_idle();
    hif.i_MEM_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== P_RST) begin
      failures++;
      $display("FAIL rst_mid_wait_outs: got %b want %b", outs, P_RST);
    end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if (outs !== 9'b0 || o_halted !== 1'b0 || o_mem_err !== 1'b0 || o_stall_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid_wait_state: outs=%b halted=%b err=%b cnt=%0d want 0/0/0/0",
               outs, o_halted, o_mem_err, o_stall_cnt);
    end
    hif.i_MEM_req = 1'b1;
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    checks++;
    if (o_halted !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_wait_count: halted=%b want 0", o_halted);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_load_use(5'(1 + (i % 30)));
      #1;
      checks++;
      if (outs !== P_LU) begin
        failures++;
        $display("FAIL sat_stall_%0d: got %b want %b", i, outs, P_LU);
      end
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (o_stall_cnt !== CNT_W'(CNT_MAX)) begin
      failures++;
      $display("FAIL saturation: cnt=%0d want %0d", o_stall_cnt, CNT_MAX);
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_random();
      rst = ($urandom_range(0, 39) == 0);
      if (($urandom_range(0, 9) == 0)) begin
        hif.i_MEM_req = 1'b1; hif.i_MEM_ready = 1'b0;
      end
      #1;
      e = exp_outs();
      checks++;
      if (outs !== e || o_halted !== m_halted || o_mem_err !== m_err ||
          o_stall_cnt !== CNT_W'(m_cnt)) begin
        failures++;
        $display("FAIL random_%0d: outs=%b halted=%b err=%b cnt=%0d want %b/%0d/%0d/%0d",
                 i, outs, o_halted, o_mem_err, o_stall_cnt, e, m_halted, m_err, m_cnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_wait = 0; m_halted = 0; m_err = 0; m_cnt = 0;
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
